// File: rtl/ecc_pkg.sv
// ECC decode shared types: codeword width codes, error classes and width helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ecc_pkg;

  typedef enum logic [1:0] {
    W8   = 2'b00,
    W16  = 2'b01,
    W32  = 2'b10,
    WRSV = 2'b11
  } cw_width_e;

  typedef enum logic [1:0] {
    NO_ERR  = 2'd0,
    SINGLE  = 2'd1,
    DOUBLE  = 2'd2,
    ILLEGAL = 2'd3
  } err_class_e;

  // Bit index width, enough to address any bit of a 32b codeword.
  localparam int unsigned IDX_W = 5;

  // Active codeword width. The reserved code masks as 8b so an illegal
  // word still leaves the stage in a defined, narrow form.
  function automatic int unsigned width_bits(cw_width_e cw);
    case (cw)
      W8:      return 8;
      W16:     return 16;
      W32:     return 32;
      default: return 8;
    endcase
  endfunction

  // Number of syndrome bits used at a given width (log2(W) + overall parity).
  function automatic int unsigned synd_bits(cw_width_e cw);
    case (cw)
      W8:      return 4;
      W16:     return 5;
      W32:     return 6;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/err_correct_if.sv
// Word bus into and out of the error-correct stage: valid/ready on both sides.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready; master drives upstream side, slave is the stage.
interface err_correct_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] NoisyCodeWord;
  logic [1:0]            Codeword_Width;
  logic [5:0]            column;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic [1:0]            num_of_errors;

  modport master (
    output in_valid, NoisyCodeWord, Codeword_Width, column, out_ready,
    input  in_ready, out_valid, data_out, num_of_errors
  );

  modport slave (
    input  in_valid, NoisyCodeWord, Codeword_Width, column, out_ready,
    output in_ready, out_valid, data_out, num_of_errors
  );

endinterface

// File: rtl/err_locator.sv
// Classifies a syndrome column as no/single/double error (or illegal width) and gives the bit to flip.
// Latency: combinational.
// Backpressure: none.
// Ports: column (syndrome in), cw (width code), err_cls (class out), bit_idx (position out).
module err_locator
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [5:0]       column,
  input  cw_width_e        cw,
  output err_class_e       err_cls,
  output logic [IDX_W-1:0] bit_idx
);

  int unsigned k;
  logic [5:0]  smask;
  logic [5:0]  s;
  logic        p;
  logic        illegal;

  always_comb begin
    k     = synd_bits(cw);
    smask = '0;
    for (int b = 0; b < 6; b++) begin
      smask[b] = (b < int'(k));
    end
    s = column & smask;
    // smask ^ (smask >> 1) is one-hot at bit k-1: the overall-parity row.
    p       = |(s & (smask ^ (smask >> 1)));
    bit_idx = IDX_W'(s & (smask >> 1));
    illegal = (cw == WRSV) || (int'(width_bits(cw)) > DATA_WIDTH);
    if (illegal)        err_cls = ILLEGAL;
    else if (s == 6'd0) err_cls = NO_ERR;
    else if (p)         err_cls = SINGLE;
    else                err_cls = DOUBLE;
  end

endmodule

// File: rtl/err_correct.sv
// Error-correct stage: masks the word to its width, flips a single-bit error, counts corrected/uncorrectable words.
// Latency: 2 register stages (S1 capture on accept edge, S2 on the next); 1 word/cycle when out_ready is high.
// Backpressure: S2 holds while out_valid && !out_ready; S1 buffers one more; in_ready falls when both are full.
// Ports: clk, rst (async, active-high), bus (err_correct_if.slave), cnt_clr, corr_cnt, uncorr_cnt.
module err_correct
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  err_correct_if.slave         bus,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] corr_cnt,
  output logic [CNT_WIDTH-1:0] uncorr_cnt
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    err_class_e            cls;
    logic [IDX_W-1:0]      idx;
  } s1_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  cw_width_e             cw_in;
  logic [DATA_WIDTH-1:0] wmask;
  err_class_e            loc_cls;
  logic [IDX_W-1:0]      loc_idx;

  logic                  s1_v;
  s1_t                   s1_q;
  logic                  s2_v;
  logic [DATA_WIDTH-1:0] s2_dat;
  err_class_e            s2_cls;
  logic [DATA_WIDTH-1:0] flip;

  logic                  s2_load;
  logic                  out_fire;

  assign cw_in = cw_width_e'(bus.Codeword_Width);

  always_comb begin
    wmask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      wmask[i] = (i < int'(width_bits(cw_in)));
    end
  end

  err_locator #(.DATA_WIDTH(DATA_WIDTH)) u_loc (
    .column  (bus.column),
    .cw      (cw_in),
    .err_cls (loc_cls),
    .bit_idx (loc_idx)
  );

  // S2 can take S1's word whenever it is empty or draining this cycle;
  // S1 can then refill in the same cycle, so in_ready follows out_ready.
  assign s2_load      = !s2_v || bus.out_ready;
  assign bus.in_ready = !s1_v || s2_load;
  assign out_fire     = s2_v && bus.out_ready;

  always_comb begin
    flip = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      flip[i] = (s1_q.cls == SINGLE) && (s1_q.idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (bus.in_ready) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_q.dat <= bus.NoisyCodeWord & wmask;
        s1_q.cls <= loc_cls;
        s1_q.idx <= loc_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      s2_dat <= '0;
      s2_cls <= NO_ERR;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_dat <= s1_q.dat ^ flip;
        s2_cls <= s1_q.cls;
      end
    end
  end

  // Counters move only on an output transfer; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_fire) begin
      if (s2_cls == SINGLE && corr_cnt != '1) begin
        corr_cnt <= corr_cnt + CNT_ONE;
      end
      if ((s2_cls == DOUBLE || s2_cls == ILLEGAL) && uncorr_cnt != '1) begin
        uncorr_cnt <= uncorr_cnt + CNT_ONE;
      end
    end
  end

  assign bus.out_valid     = s2_v;
  assign bus.data_out      = s2_dat;
  assign bus.num_of_errors = s2_cls;

endmodule

// File: tb/tb_err_correct.sv
// Bench for err_correct: table vectors, stall/saturation/reset sequences, random traffic with a queue scoreboard.
// Latency: n/a.
// Backpressure: drives out_ready held, stalled and randomised.
module tb_err_correct;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cnt_clr;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  err_correct_if #(.DATA_WIDTH(DW)) bus ();

  err_correct #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  cls;
  } exp_t;

  typedef struct {
    logic [1:0]  cw;
    logic [31:0] word;
    logic [5:0]  col;
    logic [31:0] exp_dat;
    logic [1:0]  exp_cls;
  } vec_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] m_corr = '0;
  logic [CW-1:0] m_uncorr = '0;
  logic          tog_stop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Independent reference: search the H matrix columns for the syndrome.
  function automatic exp_t ref_model(logic [1:0] cw, logic [31:0] w, logic [5:0] col);
    exp_t        r;
    int          wb;
    int          k;
    logic [31:0] d;
    logic [5:0]  s;
    logic [5:0]  h;
    if (cw == 2'b11) begin
      r.dat = w & 32'h0000_00FF;
      r.cls = 2'd3;
      return r;
    end
    wb = 8 << cw;
    k  = 4 + int'(cw);
    d  = (wb == 32) ? w : (w & ((32'd1 << wb) - 32'd1));
    s  = col & 6'((1 << k) - 1);
    r.dat = d;
    r.cls = 2'd0;
    if (s != 6'd0) begin
      r.cls = 2'd2;
      for (int j = 0; j < wb; j++) begin
        h = 6'((1 << (k - 1)) | (j & ((1 << (k - 1)) - 1)));
        if (h == s) begin
          r.dat = d ^ (32'd1 << j);
          r.cls = 2'd1;
        end
      end
    end
    return r;
  endfunction

  // Present a word and hold it until accepted; push its expectation on acceptance.
  task automatic send(input logic [1:0] cw, input logic [31:0] w, input logic [5:0] col,
                      input logic [31:0] ed, input logic [1:0] ec);
    int n = 0;
    bus.in_valid       = 1'b1;
    bus.Codeword_Width = cw;
    bus.NoisyCodeWord  = w;
    bus.column         = col;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) sb.push_back('{dat: ed, cls: ec});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_ref(input logic [1:0] cw, input logic [31:0] w, input logic [5:0] col);
    exp_t e;
    e = ref_model(cw, w, col);
    send(cw, w, col, e.dat, e.cls);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard and counter model, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      m_corr   <= '0;
      m_uncorr <= '0;
    end else begin
      chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
      chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("data_out", bus.data_out, e.dat);
          chk("num_of_errors", 32'(bus.num_of_errors), 32'(e.cls));
          if (!cnt_clr) begin
            if (e.cls == 2'd1 && m_corr != '1) m_corr <= m_corr + CW'(1);
            if (e.cls >= 2'd2 && m_uncorr != '1) m_uncorr <= m_uncorr + CW'(1);
          end
        end
      end
      if (cnt_clr) begin
        m_corr   <= '0;
        m_uncorr <= '0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    logic [31:0] held;
    logic [1:0]  rcw;
    logic [5:0]  rcol;

    vecs[0] = '{2'b10, 32'h0000_0020, 6'b100101, 32'h0000_0000, 2'd1};
    vecs[1] = '{2'b10, 32'h0000_0028, 6'b000110, 32'h0000_0028, 2'd2};
    vecs[2] = '{2'b00, 32'hFFFF_FF01, 6'b001000, 32'h0000_0000, 2'd1};
    vecs[3] = '{2'b11, 32'hFFFF_FF01, 6'b001000, 32'h0000_0001, 2'd3};
    vecs[4] = '{2'b01, 32'hABCD_1234, 6'b000000, 32'h0000_1234, 2'd0};
    vecs[5] = '{2'b01, 32'h0000_1234, 6'b011111, 32'h0000_9234, 2'd1};
    vecs[6] = '{2'b10, 32'h8000_0000, 6'b111111, 32'h0000_0000, 2'd1};
    vecs[7] = '{2'b00, 32'h0000_0055, 6'b000111, 32'h0000_0055, 2'd2};
    vecs[8] = '{2'b01, 32'hFFFF_0000, 6'b010000, 32'h0000_0001, 2'd1};

    rst                = 1'b1;
    cnt_clr            = 1'b0;
    bus.in_valid       = 1'b0;
    bus.NoisyCodeWord  = '0;
    bus.Codeword_Width = 2'b10;
    bus.column         = '0;
    bus.out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data_out", bus.data_out, 32'd0);
    chk("rst_num_of_errors", 32'(bus.num_of_errors), 32'd0);
    chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors, back to back.
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].cw, vecs[i].word, vecs[i].col, vecs[i].exp_dat, vecs[i].exp_cls);
    end
    drain("table_drain");
    chk("table_corr_cnt", 32'(corr_cnt), 32'd5);
    chk("table_uncorr_cnt", 32'(uncorr_cnt), 32'd3);

    // Latency: empty after the accept edge, valid one edge later.
    send(2'b10, 32'h0000_0020, 6'b100101, 32'h0, 2'd1);
    chk("lat_after_accept", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_data", bus.data_out, 32'h0);
    drain("lat_drain");
    chk("lat_corr_cnt", 32'(corr_cnt), 32'd6);

    // Full stall: two words buffered, third blocked, output held.
    bus.out_ready = 1'b0;
    send(2'b10, 32'h0000_0011, 6'b000000, 32'h0000_0011, 2'd0);
    send(2'b10, 32'h0000_0022, 6'b100001, 32'h0000_0020, 2'd1);
    bus.in_valid       = 1'b1;
    bus.NoisyCodeWord  = 32'h0000_0033;
    bus.column         = 6'b000011;
    @(negedge clk);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    held = bus.data_out;
    chk("stall_head", held, 32'h0000_0011);
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", bus.data_out, held);
      chk("stall_in_ready_hold", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(2'b10, 32'h0000_0033, 6'b000011, 32'h0000_0033, 2'd2);
    chk("release_v1", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("release_v2", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("release_empty", 32'(bus.out_valid), 32'd0);
    drain("stall_drain");

    // Saturation of the corrected counter, then clear on a transfer cycle.
    for (int i = 0; i < 20; i++) begin
      send_ref(2'b10, $urandom, {1'b1, 5'($urandom_range(0, 31))});
    end
    drain("sat_drain");
    chk("sat_corr_cnt", 32'(corr_cnt), 32'hF);
    send_ref(2'b10, 32'h0000_0001, 6'b100000);
    @(posedge clk);
    #1;
    chk("clr_out_valid", 32'(bus.out_valid), 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("clr_uncorr_cnt", 32'(uncorr_cnt), 32'd0);

    // Random widths/syndromes with random backpressure.
    fork
      begin
        while (!tog_stop) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      rcw  = 2'($urandom_range(0, 3));
      rcol = 6'($urandom);
      if (rcw == 2'b00) rcol[5:4] = 2'b00;
      if (rcw == 2'b01) rcol[5]   = 1'b0;
      send_ref(rcw, $urandom, rcol);
    end
    tog_stop = 1'b1;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain("rand_drain");

    // Reset with two words buffered.
    bus.out_ready = 1'b0;
    send_ref(2'b10, 32'h0000_00AA, 6'b100011);
    send_ref(2'b10, 32'h0000_00BB, 6'b000101);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("arst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    send(2'b01, 32'h0000_00F0, 6'b010100, 32'h0000_00E0, 2'd1);
    chk("post_rst_lat", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_data", bus.data_out, 32'h0000_00E0);
    @(posedge clk);
    #1;
    chk("post_rst_alone", 32'(bus.out_valid), 32'd0);
    chk("post_rst_corr_cnt", 32'(corr_cnt), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
